// File: rtl/param_readback_tx.sv
// Readback transmitter: snapshots the pulse-programmer settings and sends
// them as a 12-byte 8N1 UART frame (header, 10 payload bytes, XOR checksum).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line high, waiting for send; snapshot taken on the accepting edge
// START | start bit (0) of the current byte
// DATA  | 8 data bits of the current byte, LSB first
// STOP  | stop bit (1); then next byte or back to IDLE after byte 11
module param_readback_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send,
    input  logic [7:0]  per,
    input  logic [15:0] p1wid,
    input  logic [15:0] del,
    input  logic [15:0] p2wid,
    input  logic [7:0]  cp,
    input  logic [7:0]  p_bl,
    input  logic        pu,
    input  logic        nut,
    input  logic        bl,
    output logic        RS232_Tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'd11;
    localparam logic [7:0]    HEADER    = 8'hA5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [3:0]    byte_idx, byte_idx_nxt;
    logic          tx_q, tx_nxt;
    logic          capture;
    logic          bit_end;

    logic [7:0]    snap_per;
    logic [15:0]   snap_p1wid;
    logic [15:0]   snap_del;
    logic [15:0]   snap_p2wid;
    logic [7:0]    snap_cp;
    logic [7:0]    snap_p_bl;
    logic [2:0]    snap_flags;

    logic [7:0]    checksum;
    logic [7:0]    cur_byte;

    assign bit_end  = (bit_cnt == BIT_LAST);
    assign RS232_Tx = tx_q;
    assign busy     = (state != IDLE);
    assign done     = (state == STOP) && bit_end && (byte_idx == LAST_BYTE);

    // XOR of the ten payload bytes, taken from the snapshot only
    always_comb begin
        checksum = snap_per
                 ^ snap_p1wid[15:8] ^ snap_p1wid[7:0]
                 ^ snap_del[15:8]   ^ snap_del[7:0]
                 ^ snap_p2wid[15:8] ^ snap_p2wid[7:0]
                 ^ snap_cp ^ snap_p_bl ^ {5'b0, snap_flags};
    end

    // Frame byte selected by the byte index
    always_comb begin
        cur_byte = 8'hFF;
        case (byte_idx)
            4'd0:    cur_byte = HEADER;
            4'd1:    cur_byte = snap_per;
            4'd2:    cur_byte = snap_p1wid[15:8];
            4'd3:    cur_byte = snap_p1wid[7:0];
            4'd4:    cur_byte = snap_del[15:8];
            4'd5:    cur_byte = snap_del[7:0];
            4'd6:    cur_byte = snap_p2wid[15:8];
            4'd7:    cur_byte = snap_p2wid[7:0];
            4'd8:    cur_byte = snap_cp;
            4'd9:    cur_byte = snap_p_bl;
            4'd10:   cur_byte = {5'b0, snap_flags};
            4'd11:   cur_byte = checksum;
            default: cur_byte = 8'hFF;
        endcase
    end

    // Next-state, counters and next line level
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        bit_idx_nxt  = bit_idx;
        byte_idx_nxt = byte_idx;
        tx_nxt       = tx_q;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt  = '0;
                bit_idx_nxt  = '0;
                byte_idx_nxt = '0;
                tx_nxt       = 1'b1;
                if (send) begin
                    capture   = 1'b1;
                    state_nxt = START;
                    tx_nxt    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = DATA;
                    tx_nxt      = cur_byte[0];
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = cur_byte[bit_idx_nxt];
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    if (byte_idx == LAST_BYTE) begin
                        state_nxt = IDLE;
                    end else begin
                        byte_idx_nxt = byte_idx + 4'd1;
                        state_nxt    = START;
                        tx_nxt       = 1'b0;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Counters and registered line driver; reset forces the line high at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b1;
        end else begin
            bit_cnt  <= bit_cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            byte_idx <= byte_idx_nxt;
            tx_q     <= tx_nxt;
        end
    end

    // Parameter snapshot, frozen for the whole frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_per   <= '0;
            snap_p1wid <= '0;
            snap_del   <= '0;
            snap_p2wid <= '0;
            snap_cp    <= '0;
            snap_p_bl  <= '0;
            snap_flags <= '0;
        end else if (capture) begin
            snap_per   <= per;
            snap_p1wid <= p1wid;
            snap_del   <= del;
            snap_p2wid <= p2wid;
            snap_cp    <= cp;
            snap_p_bl  <= p_bl;
            snap_flags <= {bl, nut, pu};
        end
    end

endmodule

// File: tb/tb_param_readback_tx.sv
module tb_param_readback_tx;

    logic        clk;
    logic        reset;
    logic        send_f, send_s;
    logic [7:0]  per, cp, p_bl;
    logic [15:0] p1wid, del, p2wid;
    logic        pu, nut, bl;
    logic        tx_f, busy_f, done_f;
    logic        tx_s, busy_s, done_s;

    int          n_chk = 0;
    int          n_err = 0;

    logic [7:0]  exp_bytes [12];
    logic [7:0]  rx_bytes  [12];
    int          cap_busy, cap_done, cap_done_at, cap_wave_err;
    int          poke_kind, poke_cycle;

    param_readback_tx #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .send(send_f),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .cp(cp), .p_bl(p_bl), .pu(pu), .nut(nut), .bl(bl),
        .RS232_Tx(tx_f), .busy(busy_f), .done(done_f)
    );

    param_readback_tx dut_slow (
        .clk(clk), .reset(reset), .send(send_s),
        .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .cp(cp), .p_bl(p_bl), .pu(pu), .nut(nut), .bl(bl),
        .RS232_Tx(tx_s), .busy(busy_s), .done(done_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_vec(input int v);
        if (v == 1) begin
            per = 8'h10; p1wid = 16'h0032; del = 16'h00C8; p2wid = 16'h0064;
            cp = 8'h01; p_bl = 8'h00; pu = 1'b1; nut = 1'b0; bl = 1'b0;
            exp_bytes = '{8'hA5, 8'h10, 8'h00, 8'h32, 8'h00, 8'hC8,
                          8'h00, 8'h64, 8'h01, 8'h00, 8'h01, 8'h8E};
        end else begin
            per = 8'hAB; p1wid = 16'h1234; del = 16'hBEEF; p2wid = 16'h0F0F;
            cp = 8'h55; p_bl = 8'h3C; pu = 1'b1; nut = 1'b1; bl = 1'b1;
            exp_bytes = '{8'hA5, 8'hAB, 8'h12, 8'h34, 8'hBE, 8'hEF,
                          8'h0F, 8'h0F, 8'h55, 8'h3C, 8'h07, 8'hB2};
        end
    endtask

    // Called on the negedge of the first frame cycle; returns on the negedge
    // of the cycle right after the frame.
    task automatic capture(input bit slow, input int cpb);
        logic t, e;
        int   b, j, k;
        cap_busy = 0; cap_done = 0; cap_done_at = -1; cap_wave_err = 0;
        for (int i = 0; i < 12; i++) rx_bytes[i] = '0;
        for (int c = 0; c < 120 * cpb; c++) begin
            t = slow ? tx_s : tx_f;
            if (slow ? busy_s : busy_f) cap_busy++;
            if (slow ? done_s : done_f) begin
                cap_done++;
                cap_done_at = c;
            end
            b = c / cpb;
            j = b / 10;
            k = b % 10;
            if (k == 0)      e = 1'b0;
            else if (k == 9) e = 1'b1;
            else             e = exp_bytes[j][k-1];
            if (t !== e) cap_wave_err++;
            if ((c % cpb) == (cpb / 2) && k >= 1 && k <= 8) rx_bytes[j][k-1] = t;
            if (!slow && poke_kind == 1 && c == poke_cycle) p1wid = 16'hFFFF;
            if (!slow && poke_kind == 2 && c == poke_cycle) send_f = 1'b1;
            if (!slow && poke_kind == 2 && c == poke_cycle + 1) send_f = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string name, input bit slow, input int cpb);
        for (int j = 0; j < 12; j++)
            chk($sformatf("%s_byte%0d", name, j), 32'(rx_bytes[j]), 32'(exp_bytes[j]));
        chk({name, "_wave"}, cap_wave_err, 0);
        chk({name, "_busy_cycles"}, cap_busy, 120 * cpb);
        chk({name, "_done_count"}, cap_done, 1);
        chk({name, "_done_at"}, cap_done_at, 120 * cpb - 1);
        chk({name, "_busy_after"}, 32'(slow ? busy_s : busy_f), 0);
        chk({name, "_tx_after"}, 32'(slow ? tx_s : tx_f), 1);
    endtask

    task automatic start_fast(input bit hold);
        @(negedge clk) send_f = 1'b1;
        @(negedge clk);
        if (!hold) send_f = 1'b0;
    endtask

    task automatic quiet_check(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (tx_f !== 1'b1 || busy_f !== 1'b0) lows++;
            @(negedge clk);
        end
        chk(tag, lows, 0);
    endtask

    initial begin
        int gap;
        reset = 1'b1; send_f = 1'b0; send_s = 1'b0;
        poke_kind = 0; poke_cycle = 0;
        set_vec(1);
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_f), 1);
        chk("rst_busy", 32'(busy_f), 0);
        chk("rst_done", 32'(done_f), 0);
        chk("rst_tx_slow", 32'(tx_s), 1);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // nominal frame
        start_fast(1'b0);
        capture(1'b0, 4);
        check_frame("nom", 1'b0, 4);

        // snapshot: p1wid changes two cycles into the frame
        set_vec(1);
        poke_kind = 1; poke_cycle = 2;
        start_fast(1'b0);
        capture(1'b0, 4);
        check_frame("snap", 1'b0, 4);
        poke_kind = 0;
        set_vec(1);

        // send pulsed while busy is ignored
        poke_kind = 2; poke_cycle = 100;
        start_fast(1'b0);
        capture(1'b0, 4);
        check_frame("ign", 1'b0, 4);
        poke_kind = 0;
        quiet_check("ign_no_second", 20);

        // held send: back-to-back frames with one idle cycle between
        start_fast(1'b1);
        capture(1'b0, 4);
        check_frame("held1", 1'b0, 4);
        gap = 0;
        while (tx_f === 1'b1 && gap < 5) begin
            @(negedge clk);
            gap++;
        end
        chk("held_gap", gap, 1);
        send_f = 1'b0;
        capture(1'b0, 4);
        check_frame("held2", 1'b0, 4);
        quiet_check("held_no_third", 20);

        // reset in the middle of a frame
        set_vec(2);
        start_fast(1'b0);
        repeat (200) @(negedge clk);
        chk("midrst_tx_before", 32'(busy_f), 1);
        reset = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx_f), 1);
        chk("midrst_busy", 32'(busy_f), 0);
        chk("midrst_done", 32'(done_f), 0);
        @(negedge clk) reset = 1'b0;
        quiet_check("midrst_no_resume", 30);
        start_fast(1'b0);
        capture(1'b0, 4);
        check_frame("after_rst", 1'b0, 4);

        // default bit timing on the slow instance
        set_vec(1);
        @(negedge clk) send_s = 1'b1;
        @(negedge clk) send_s = 1'b0;
        capture(1'b1, 104);
        check_frame("slow", 1'b1, 104);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
